rambus_resp_mem: RTL and testbench

//  Wishbone classic responder for the RAMBus port: the target end of the spell core's RAMBus initiator.

---
 rtl/rambus_resp_mem.sv | 202 ++++++++++++++++++++
 tb/tb_rambus_resp_mem.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rambus_resp_mem.sv
// -----------------------------------------------------------------------------
// rambus_resp_mem
//   Wishbone classic responder for the RAMBus port (target end of the spell
//   core's RAMBus initiator). Single-port 32-bit word memory with byte-lane
//   writes and a fixed, parameterised wait-state count. One request in flight,
//   one ack per request.
//
// Parameters
//   ADDR_W       word-address width, depth = 2**ADDR_W words
//   WAIT_STATES  extra cycles between request capture and ack (0..15)
//
// Ports
//   rambus_wb_clk_i    clock, rising edge
//   rambus_wb_rst_n_i  asynchronous active-low reset
//   rambus_wb_cyc_i    bus cycle valid
//   rambus_wb_stb_i    strobe (request = cyc & stb)
//   rambus_wb_we_i     1 = write, 0 = read
//   rambus_wb_sel_i    byte-lane enables
//   rambus_wb_dat_i    write data
//   rambus_wb_addr_i   word address
//   rambus_wb_ack_o    one-cycle transfer-complete pulse
//   rambus_wb_dat_o    read data, zero outside the ack cycle
//
// Optional feature (macro RAMBUS_RESP_STATS_EN)
//   rd_count_o / wr_count_o : saturating counts of acked reads / writes.
// -----------------------------------------------------------------------------
module rambus_resp_mem #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 0
) (
  input  logic              rambus_wb_clk_i,
  input  logic              rambus_wb_rst_n_i,
  input  logic              rambus_wb_cyc_i,
  input  logic              rambus_wb_stb_i,
  input  logic              rambus_wb_we_i,
  input  logic [3:0]        rambus_wb_sel_i,
  input  logic [31:0]       rambus_wb_dat_i,
  input  logic [ADDR_W-1:0] rambus_wb_addr_i,
  output logic              rambus_wb_ack_o,
  output logic [31:0]       rambus_wb_dat_o
`ifdef RAMBUS_RESP_STATS_EN
  ,
  output logic [15:0]       rd_count_o,
  output logic [15:0]       wr_count_o
`endif
);

  localparam int         DEPTH = 1 << ADDR_W;
  localparam logic [3:0] WS_L  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [3:0]          cnt_r;
  logic [3:0]          cnt_s;
  logic [ADDR_W-1:0]   addr_r;
  logic                we_r;
  logic [3:0]          sel_r;
  logic [31:0]         wdat_r;
  logic                ack_r;
  logic [31:0]         rdat_r;
  logic                req_s;
  logic                capture_s;
  logic [ADDR_W-1:0]   rd_addr_s;
  logic                rd_we_s;
  logic [31:0]         mem_r [0:DEPTH-1];

  // Merge new write data into an old word, lane by lane.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_word;
    for (int n = 0; n < 4; n++) begin
      if (sel[n]) begin
        res[8*n +: 8] = new_word[8*n +: 8];
      end else begin
        res[8*n +: 8] = old_word[8*n +: 8];
      end
    end
    return res;
  endfunction

  assign req_s     = rambus_wb_cyc_i & rambus_wb_stb_i;
  assign capture_s = (state_r == ST_IDLE) && req_s;
  // With zero wait states the ack-entry edge is the capture edge itself, so
  // the read address/direction must come straight from the bus.
  assign rd_addr_s = (state_r == ST_IDLE) ? rambus_wb_addr_i : addr_r;
  assign rd_we_s   = (state_r == ST_IDLE) ? rambus_wb_we_i   : we_r;

  // Next-state and wait-counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          cnt_s   = WS_L;
          state_s = (WS_L != 4'd0) ? ST_WAIT : ST_ACK;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // Dropping cyc aborts, including on the edge that would enter ACK.
        if (!rambus_wb_cyc_i) begin
          state_s = ST_IDLE;
          cnt_s   = 4'd0;
        end else if (cnt_r <= 4'd1) begin
          state_s = ST_ACK;
          cnt_s   = 4'd0;
        end else begin
          cnt_s   = cnt_r - 4'd1;
        end
      end
      ST_ACK: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // State, counter and registered bus outputs.
  always_ff @(posedge rambus_wb_clk_i or negedge rambus_wb_rst_n_i) begin
    if (!rambus_wb_rst_n_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      ack_r   <= 1'b0;
      rdat_r  <= 32'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ack_r   <= (state_s == ST_ACK);
      if ((state_s == ST_ACK) && !rd_we_s) begin
        rdat_r <= mem_r[rd_addr_s];
      end else begin
        rdat_r <= 32'd0;
      end
    end
  end

  // Request capture; bus inputs are ignored outside IDLE.
  always_ff @(posedge rambus_wb_clk_i or negedge rambus_wb_rst_n_i) begin
    if (!rambus_wb_rst_n_i) begin
      addr_r <= '0;
      we_r   <= 1'b0;
      sel_r  <= 4'd0;
      wdat_r <= 32'd0;
    end else if (capture_s) begin
      addr_r <= rambus_wb_addr_i;
      we_r   <= rambus_wb_we_i;
      sel_r  <= rambus_wb_sel_i;
      wdat_r <= rambus_wb_dat_i;
    end
  end

  // Memory write on the edge that closes the ACK cycle; a reset during ACK
  // leaves IDLE in state_r, so the write is dropped.
  always_ff @(posedge rambus_wb_clk_i) begin
    if ((state_r == ST_ACK) && we_r) begin
      mem_r[addr_r] <= merge_lanes(mem_r[addr_r], wdat_r, sel_r);
    end
  end

  assign rambus_wb_ack_o = ack_r;
  assign rambus_wb_dat_o = rdat_r;

`ifdef RAMBUS_RESP_STATS_EN
  logic [15:0] rd_cnt_r;
  logic [15:0] wr_cnt_r;

  // Saturating counts of completed (acked) transfers.
  always_ff @(posedge rambus_wb_clk_i or negedge rambus_wb_rst_n_i) begin
    if (!rambus_wb_rst_n_i) begin
      rd_cnt_r <= 16'd0;
      wr_cnt_r <= 16'd0;
    end else if (state_r == ST_ACK) begin
      if (we_r) begin
        if (wr_cnt_r != 16'hFFFF) begin
          wr_cnt_r <= wr_cnt_r + 16'd1;
        end
      end else begin
        if (rd_cnt_r != 16'hFFFF) begin
          rd_cnt_r <= rd_cnt_r + 16'd1;
        end
      end
    end
  end

  assign rd_count_o = rd_cnt_r;
  assign wr_count_o = wr_cnt_r;
`endif

endmodule

// File: tb/tb_rambus_resp_mem.sv
// -----------------------------------------------------------------------------
// tb_rambus_resp_mem
//   Directed bench for rambus_resp_mem. Instance u0 has WAIT_STATES=0,
//   instance u3 has WAIT_STATES=3; each has its own bus signals.
// -----------------------------------------------------------------------------
module tb_rambus_resp_mem;

  logic        clk_s;
  logic        rst_n_s;
  logic [1:0]  cyc_s;
  logic [1:0]  stb_s;
  logic [1:0]  we_s;
  logic [3:0]  sel_s  [2];
  logic [31:0] wdat_s [2];
  logic [8:0]  addr_s [2];
  logic        ack0_s;
  logic        ack3_s;
  logic [31:0] dat0_s;
  logic [31:0] dat3_s;
`ifdef RAMBUS_RESP_STATS_EN
  logic [15:0] rdc0_s, wrc0_s, rdc3_s, wrc3_s;
`endif

  int errors = 0;
  int checks = 0;
  int exp_rd [2];
  int exp_wr [2];

  rambus_resp_mem #(.ADDR_W(9), .WAIT_STATES(0)) u0 (
    .rambus_wb_clk_i   (clk_s),
    .rambus_wb_rst_n_i (rst_n_s),
    .rambus_wb_cyc_i   (cyc_s[0]),
    .rambus_wb_stb_i   (stb_s[0]),
    .rambus_wb_we_i    (we_s[0]),
    .rambus_wb_sel_i   (sel_s[0]),
    .rambus_wb_dat_i   (wdat_s[0]),
    .rambus_wb_addr_i  (addr_s[0]),
    .rambus_wb_ack_o   (ack0_s),
    .rambus_wb_dat_o   (dat0_s)
`ifdef RAMBUS_RESP_STATS_EN
    ,
    .rd_count_o        (rdc0_s),
    .wr_count_o        (wrc0_s)
`endif
  );

  rambus_resp_mem #(.ADDR_W(9), .WAIT_STATES(3)) u3 (
    .rambus_wb_clk_i   (clk_s),
    .rambus_wb_rst_n_i (rst_n_s),
    .rambus_wb_cyc_i   (cyc_s[1]),
    .rambus_wb_stb_i   (stb_s[1]),
    .rambus_wb_we_i    (we_s[1]),
    .rambus_wb_sel_i   (sel_s[1]),
    .rambus_wb_dat_i   (wdat_s[1]),
    .rambus_wb_addr_i  (addr_s[1]),
    .rambus_wb_ack_o   (ack3_s),
    .rambus_wb_dat_o   (dat3_s)
`ifdef RAMBUS_RESP_STATS_EN
    ,
    .rd_count_o        (rdc3_s),
    .wr_count_o        (wrc3_s)
`endif
  );

  initial clk_s = 1'b0;
  always #5 clk_s = ~clk_s;

  function automatic logic get_ack(input int idx);
    return (idx == 0) ? ack0_s : ack3_s;
  endfunction

  function automatic logic [31:0] get_dat(input int idx);
    return (idx == 0) ? dat0_s : dat3_s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transfer on instance idx; checks latency, read data and
  // that dat_o stays zero before the ack.
  task automatic xfer(input int idx, input logic we, input logic [3:0] sel,
                      input logic [8:0] addr, input logic [31:0] wd,
                      input int exp_lat, input logic [31:0] exp_rdat,
                      input string tag);
    int lat;
    logic got;
    @(negedge clk_s);
    cyc_s[idx] = 1'b1; stb_s[idx] = 1'b1; we_s[idx] = we;
    sel_s[idx] = sel; addr_s[idx] = addr; wdat_s[idx] = wd;
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk_s);
      lat++;
      if (get_ack(idx)) begin
        got = 1'b1;
      end else begin
        chk({tag, "_dat_idle"}, get_dat(idx), 32'd0);
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (!we) begin
      chk({tag, "_rdat"}, get_dat(idx), exp_rdat);
      exp_rd[idx]++;
    end else begin
      exp_wr[idx]++;
    end
    cyc_s[idx] = 1'b0; stb_s[idx] = 1'b0;
  endtask

  initial begin
    int t, last, n;
    logic got;
    rst_n_s = 1'b0;
    cyc_s = 2'b00; stb_s = 2'b00; we_s = 2'b00;
    for (int i = 0; i < 2; i++) begin
      sel_s[i] = 4'h0; wdat_s[i] = 32'd0; addr_s[i] = 9'd0;
      exp_rd[i] = 0; exp_wr[i] = 0;
    end
    repeat (3) @(negedge clk_s);
    chk("rst_ack0", {31'd0, ack0_s}, 32'd0);
    chk("rst_dat0", dat0_s, 32'd0);
    chk("rst_ack3", {31'd0, ack3_s}, 32'd0);
    chk("rst_dat3", dat3_s, 32'd0);
    rst_n_s = 1'b1;

    // Zero wait states: ack one cycle after the request.
    xfer(0, 1'b1, 4'hF, 9'h005, 32'hDEADBEEF, 1, 32'd0, "ws0_wr");
    xfer(0, 1'b0, 4'hF, 9'h005, 32'd0, 1, 32'hDEADBEEF, "ws0_rd");

    // Byte lanes, and a sel=0 write that must leave memory untouched.
    xfer(0, 1'b1, 4'hF, 9'h010, 32'h11223344, 1, 32'd0, "lane_wr1");
    xfer(0, 1'b1, 4'h5, 9'h010, 32'hAABBCCDD, 1, 32'd0, "lane_wr2");
    xfer(0, 1'b1, 4'h0, 9'h010, 32'hFFFFFFFF, 1, 32'd0, "sel0_wr");
    xfer(0, 1'b0, 4'h0, 9'h010, 32'd0, 1, 32'h11BB33DD, "lane_rd");

    // Three wait states: ack in cycle N+4.
    xfer(1, 1'b1, 4'hF, 9'h021, 32'hCAFEF00D, 4, 32'd0, "ws3_wr");
    xfer(1, 1'b0, 4'hF, 9'h021, 32'd0, 4, 32'hCAFEF00D, "ws3_rd");

    // Abort in WAIT: no ack, no write.
    xfer(1, 1'b1, 4'hF, 9'h020, 32'h00000000, 4, 32'd0, "abort_pre");
    @(negedge clk_s);
    cyc_s[1] = 1'b1; stb_s[1] = 1'b1; we_s[1] = 1'b1;
    sel_s[1] = 4'hF; addr_s[1] = 9'h020; wdat_s[1] = 32'h00000055;
    @(negedge clk_s);
    chk("abort_ack_a", {31'd0, ack3_s}, 32'd0);
    @(negedge clk_s);
    chk("abort_ack_b", {31'd0, ack3_s}, 32'd0);
    cyc_s[1] = 1'b0; stb_s[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_s);
      chk("abort_ack_c", {31'd0, ack3_s}, 32'd0);
    end
    xfer(1, 1'b0, 4'hF, 9'h020, 32'd0, 4, 32'h00000000, "abort_rd");

    // stb dropped after capture while cyc stays high: still completes.
    @(negedge clk_s);
    cyc_s[1] = 1'b1; stb_s[1] = 1'b1; we_s[1] = 1'b1;
    sel_s[1] = 4'hF; addr_s[1] = 9'h022; wdat_s[1] = 32'h00000077;
    @(negedge clk_s);
    stb_s[1] = 1'b0;
    wdat_s[1] = 32'h12345678;
    n = 1; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk_s);
      n++;
      if (ack3_s) got = 1'b1;
    end
    chk("stblow_lat", 32'(n), 32'd4);
    cyc_s[1] = 1'b0;
    exp_wr[1]++;
    xfer(1, 1'b0, 4'hF, 9'h022, 32'd0, 4, 32'h00000077, "stblow_rd");

    // Held stb: four reads, acks 2+3 cycles apart.
    for (int k = 0; k < 4; k++) begin
      xfer(1, 1'b1, 4'hF, 9'(9'h030 + k), 32'hA0000000 + 32'(k), 4, 32'd0, "held_pre");
    end
    @(negedge clk_s);
    cyc_s[1] = 1'b1; stb_s[1] = 1'b1; we_s[1] = 1'b0; addr_s[1] = 9'h030;
    t = 0; last = 0;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0; n = 0;
      while (!got && n < 20) begin
        @(negedge clk_s);
        t++; n++;
        if (ack3_s) got = 1'b1;
      end
      chk("held_gap", 32'(t - last), (k == 0) ? 32'd4 : 32'd5);
      chk("held_rdat", dat3_s, 32'hA0000000 + 32'(k));
      last = t;
      addr_s[1] = 9'(9'h031 + k);
      exp_rd[1]++;
    end
    cyc_s[1] = 1'b0; stb_s[1] = 1'b0;

`ifdef RAMBUS_RESP_STATS_EN
    chk("stats_wr0", {16'd0, wrc0_s}, 32'(exp_wr[0]));
    chk("stats_rd0", {16'd0, rdc0_s}, 32'(exp_rd[0]));
    chk("stats_wr3", {16'd0, wrc3_s}, 32'(exp_wr[1]));
    chk("stats_rd3", {16'd0, rdc3_s}, 32'(exp_rd[1]));
`endif

    // Reset asserted mid-WAIT.
    @(negedge clk_s);
    cyc_s[1] = 1'b1; stb_s[1] = 1'b1; we_s[1] = 1'b0; addr_s[1] = 9'h030;
    @(negedge clk_s);
    @(negedge clk_s);
    rst_n_s = 1'b0;
    #1;
    chk("rst_mid_ack", {31'd0, ack3_s}, 32'd0);
    @(negedge clk_s);
    chk("rst_mid_ack2", {31'd0, ack3_s}, 32'd0);
    cyc_s[1] = 1'b0; stb_s[1] = 1'b0;
    rst_n_s = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_s);
      chk("rst_mid_idle", {31'd0, ack3_s}, 32'd0);
    end
`ifdef RAMBUS_RESP_STATS_EN
    chk("stats_rst_wr", {16'd0, wrc0_s}, 32'd0);
    chk("stats_rst_rd", {16'd0, rdc0_s}, 32'd0);
`endif
    xfer(1, 1'b0, 4'hF, 9'h031, 32'd0, 4, 32'hA0000001, "post_rst_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
